jace_audio_mixer: RTL and testbench



---
 rtl/jace_audio_pkg.sv | 30 +++
 rtl/jace_audio_lpf.sv | 42 ++++
 rtl/jace_audio_mixer.sv | 170 +++++++++++++++++
 tb/tb_jace_audio_mixer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jace_audio_pkg.sv
// -----------------------------------------------------------------------------
// jace_audio_pkg
// Shared definitions for the Jupiter ACE audio mixer:
//   - state_t        : sequencing FSM states (also exposed as a debug output)
//   - *_LEVEL_DEF    : default PCM contributions of the beeper/tape bits
//   - ex()           : expands an 8-bit AY level to a 13-bit full-scale value
// -----------------------------------------------------------------------------
package jace_audio_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BEEP = 3'd1,
    S_A    = 3'd2,
    S_B    = 3'd3,
    S_C    = 3'd4,
    S_SAT  = 3'd5,
    S_FILT = 3'd6
  } state_t;

  localparam logic [15:0] SPK_LEVEL_DEF = 16'h1C00;
  localparam logic [15:0] EAR_LEVEL_DEF = 16'h0E00;
  localparam logic [15:0] MIC_LEVEL_DEF = 16'h07F0;

  // Replicating the top bits into the LSBs makes 8'hFF map to 16'h1FFF
  // exactly, so full-scale AY output is a clean 13-bit maximum.
  function automatic logic [15:0] ex(input logic [7:0] v);
    return {3'b000, v, v[7:3]};
  endfunction

endpackage

// File: rtl/jace_audio_lpf.sv
// -----------------------------------------------------------------------------
// jace_audio_lpf
// One-pole low-pass filter, y <= y + ((x - y) >>> FILT_SHIFT), evaluated in
// 17-bit signed arithmetic. The output register is the filter state.
// FILT_SHIFT = 0 degenerates to a plain load of x.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : update y from x this cycle
//   x            : new input sample, 0..16'h7FFF
//   y            : filtered output, 0..16'h7FFF
// -----------------------------------------------------------------------------
module jace_audio_lpf #(
  parameter int FILT_SHIFT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] x,
  output logic [15:0] y
);

  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [16:0] y_next;

  // Both x and y stay within 0..16'h7FFF and the step never overshoots x,
  // so the 17-bit signed result always fits back into 16 bits.
  always_comb begin
    diff   = $signed({1'b0, x}) - $signed({1'b0, y});
    step   = diff >>> FILT_SHIFT;
    y_next = $signed({1'b0, y}) + step;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y <= '0;
    end else if (load) begin
      y <= y_next[15:0];
    end
  end

endmodule

// File: rtl/jace_audio_mixer.sv
// -----------------------------------------------------------------------------
// jace_audio_mixer
// Registered audio mixer for the Jupiter ACE core. Every DIV clocks it
// snapshots spk/mic/ear and the three AY levels, mixes them into left/right
// PCM over a short FSM sequence, saturates, filters and publishes the result.
// Ports:
//   clk65, reset_n          : 6.5 MHz core clock, asynchronous active-low reset
//   spk, mic                : beeper / tape-out bits (synchronous)
//   ear                     : tape-in pin (asynchronous, synchronized here)
//   ay_a, ay_b, ay_c        : AY channel levels, unsigned
//   audio_l, audio_r        : PCM output, 0..16'h7FFF
//   sample_valid            : one-cycle pulse when audio_l/audio_r update
//   state                   : FSM state, for debug/observation
// Output semantics: sample_valid is a single-cycle strobe with no back-pressure;
// audio_l/audio_r change only in the cycle sample_valid is high and hold until
// the next strobe.
// Sample timing: tick in cycle T -> new outputs and sample_valid in T+7.
// -----------------------------------------------------------------------------
module jace_audio_mixer
  import jace_audio_pkg::*;
#(
  parameter int          DIV        = 136,
  parameter logic [15:0] SPK_LEVEL  = SPK_LEVEL_DEF,
  parameter logic [15:0] EAR_LEVEL  = EAR_LEVEL_DEF,
  parameter logic [15:0] MIC_LEVEL  = MIC_LEVEL_DEF,
  parameter int          FILT_SHIFT = 0
) (
  input  logic        clk65,
  input  logic        reset_n,
  input  logic        spk,
  input  logic        mic,
  input  logic        ear,
  input  logic [7:0]  ay_a,
  input  logic [7:0]  ay_b,
  input  logic [7:0]  ay_c,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        sample_valid,
  output state_t      state
);

  // The FSM needs 7 cycles per sample, so a shorter period would let a tick
  // land while a sample is still being built.
  if (DIV < 8 || FILT_SHIFT < 0 || FILT_SHIFT > 7) begin : g_bad_param
    $error("jace_audio_mixer: DIV must be >= 8 and FILT_SHIFT within 0..7");
  end

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          ear_meta, ear_s;
  logic          spk_q, mic_q, ear_q;
  logic [7:0]    a_q, b_q, c_q;
  logic [16:0]   acc_l, acc_r;
  logic [16:0]   beep;
  logic [15:0]   x_l, x_r;
  logic          load;

  assign tick = (div_cnt == CW'(DIV - 1));
  assign load = (state == S_FILT);

  // ear is asynchronous to clk65; only ear_s is used downstream.
  always_ff @(posedge clk65 or negedge reset_n) begin
    if (!reset_n) begin
      ear_meta <= 1'b0;
      ear_s    <= 1'b0;
    end else begin
      ear_meta <= ear;
      ear_s    <= ear_meta;
    end
  end

  always_ff @(posedge clk65 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    beep = 17'd0;
    if (spk_q) beep = beep + {1'b0, SPK_LEVEL};
    if (ear_q) beep = beep + {1'b0, EAR_LEVEL};
    if (mic_q) beep = beep + {1'b0, MIC_LEVEL};
  end

  always_ff @(posedge clk65 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      spk_q        <= 1'b0;
      mic_q        <= 1'b0;
      ear_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      x_l          <= '0;
      x_r          <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            spk_q <= spk;
            mic_q <= mic;
            ear_q <= ear_s;
            a_q   <= ay_a;
            b_q   <= ay_b;
            c_q   <= ay_c;
            acc_l <= '0;
            acc_r <= '0;
            state <= S_BEEP;
          end
        end
        S_BEEP: begin
          acc_l <= acc_l + beep;
          acc_r <= acc_r + beep;
          state <= S_A;
        end
        S_A: begin
          acc_l <= acc_l + {1'b0, ex(a_q)};
          state <= S_B;
        end
        S_B: begin
          acc_r <= acc_r + {1'b0, ex(b_q)};
          state <= S_C;
        end
        S_C: begin
          acc_l <= acc_l + {1'b0, ex(c_q)};
          acc_r <= acc_r + {1'b0, ex(c_q)};
          state <= S_SAT;
        end
        S_SAT: begin
          x_l   <= (acc_l > 17'h07FFF) ? 16'h7FFF : acc_l[15:0];
          x_r   <= (acc_r > 17'h07FFF) ? 16'h7FFF : acc_r[15:0];
          state <= S_FILT;
        end
        S_FILT: begin
          // The filters load on this same edge (load = state == S_FILT).
          sample_valid <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  jace_audio_lpf #(.FILT_SHIFT(FILT_SHIFT)) u_lpf_l (
    .clk     (clk65),
    .reset_n (reset_n),
    .load    (load),
    .x       (x_l),
    .y       (audio_l)
  );

  jace_audio_lpf #(.FILT_SHIFT(FILT_SHIFT)) u_lpf_r (
    .clk     (clk65),
    .reset_n (reset_n),
    .load    (load),
    .x       (x_r),
    .y       (audio_r)
  );

endmodule

// File: tb/tb_jace_audio_mixer.sv
// -----------------------------------------------------------------------------
// tb_jace_audio_mixer
// Three mixers run in lockstep on shared stimulus: default levels (u_main),
// SPK_LEVEL = 16'h4000 (u_sat) and FILT_SHIFT = 2 (u_filt). Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jace_audio_mixer;
  import jace_audio_pkg::*;

  localparam int DIV = 136;

  // ---------------- clock / reset ----------------
  logic clk65   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk65 = ~clk65;

  logic       spk = 1'b0, mic = 1'b0, ear = 1'b0;
  logic [7:0] ay_a = '0, ay_b = '0, ay_c = '0;

  logic [15:0] l0, r0, l1, r1, l2, r2;
  logic        v0, v1, v2;
  state_t      st0, st1, st2;

  jace_audio_mixer #(.DIV(DIV)) u_main (
    .clk65(clk65), .reset_n(reset_n), .spk(spk), .mic(mic), .ear(ear),
    .ay_a(ay_a), .ay_b(ay_b), .ay_c(ay_c),
    .audio_l(l0), .audio_r(r0), .sample_valid(v0), .state(st0)
  );

  jace_audio_mixer #(.DIV(DIV), .SPK_LEVEL(16'h4000)) u_sat (
    .clk65(clk65), .reset_n(reset_n), .spk(spk), .mic(mic), .ear(ear),
    .ay_a(ay_a), .ay_b(ay_b), .ay_c(ay_c),
    .audio_l(l1), .audio_r(r1), .sample_valid(v1), .state(st1)
  );

  jace_audio_mixer #(.DIV(DIV), .FILT_SHIFT(2)) u_filt (
    .clk65(clk65), .reset_n(reset_n), .spk(spk), .mic(mic), .ear(ear),
    .ay_a(ay_a), .ay_b(ay_b), .ay_c(ay_c),
    .audio_l(l2), .audio_r(r2), .sample_valid(v2), .state(st2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];
  int filt_l = 0;
  int filt_r = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // {3'b000, v, v[7:3]} written arithmetically
  function automatic int ay_exp(input logic [7:0] v);
    return int'(v) * 32 + int'(v) / 8;
  endfunction

  function automatic int mix_side(input bit left, input bit s, input bit e, input bit m,
                                  input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] c, input int spk_lvl);
    int t;
    t = (s ? spk_lvl : 0) + (e ? 'h0E00 : 0) + (m ? 'h07F0 : 0);
    t = t + (left ? ay_exp(a) : ay_exp(b)) + ay_exp(c);
    if (t > 'h7FFF) t = 'h7FFF;
    return t;
  endfunction

  // Expected result of the sample that snapshots the current inputs, with
  // e_snap as the ear value that sample is expected to see.
  task automatic push_expect(input bit e_snap);
    int ml, mr, sl, sr;
    ml = mix_side(1'b1, spk, e_snap, mic, ay_a, ay_b, ay_c, 'h1C00);
    mr = mix_side(1'b0, spk, e_snap, mic, ay_a, ay_b, ay_c, 'h1C00);
    sl = mix_side(1'b1, spk, e_snap, mic, ay_a, ay_b, ay_c, 'h4000);
    sr = mix_side(1'b0, spk, e_snap, mic, ay_a, ay_b, ay_c, 'h4000);
    filt_l = filt_l + ((ml - filt_l) >>> 2);
    filt_r = filt_r + ((mr - filt_r) >>> 2);
    exp_q0.push_back({ml[15:0], mr[15:0]});
    exp_q1.push_back({sl[15:0], sr[15:0]});
    exp_q2.push_back({filt_l[15:0], filt_r[15:0]});
  endtask

  // Waits (bounded) for the next sample_valid; n = falling edges waited.
  task automatic wait_sample(output int n);
    n = 0;
    do begin
      @(negedge clk65);
      n++;
    end while (v0 !== 1'b1 && n < 400);
    check("valid_seen", {31'd0, v0}, 32'd1);
  endtask

  task automatic compare_sample(input string tag);
    logic [31:0] e0, e1, e2;
    check({tag, "_qdepth"}, exp_q0.size(), 32'd1);
    e0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : 32'hxxxx_xxxx;
    e1 = (exp_q1.size() > 0) ? exp_q1.pop_front() : 32'hxxxx_xxxx;
    e2 = (exp_q2.size() > 0) ? exp_q2.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_main"}, {l0, r0}, e0);
    check({tag, "_sat"},  {l1, r1}, e1);
    check({tag, "_filt"}, {l2, r2}, e2);
    check({tag, "_lockstep"}, {30'd0, v1, v2}, 32'd3);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_main"}, {l0, r0}, 32'd0);
    check({tag, "_out_sat"},  {l1, r1}, 32'd0);
    check({tag, "_out_filt"}, {l2, r2}, 32'd0);
    check({tag, "_valid"},    {29'd0, v0, v1, v2}, 32'd0);
    check({tag, "_state"},    32'(st0), 32'(S_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int k;

    // Reset values
    repeat (4) @(negedge clk65);
    reset_checks("reset");

    // First tick after release: valid in cycle DIV-1+7
    push_expect(1'b0);
    reset_n = 1'b1;
    wait_sample(n);
    check("first_valid_cycle", n, 32'd142);
    compare_sample("zero");

    // ay_a alone, then held (filter step response)
    ay_a = 8'h80;
    push_expect(1'b0);
    wait_sample(n);
    check("period", n, DIV);
    compare_sample("ay_a");
    check("ay_a_lit", {l0, r0}, {16'h1010, 16'h0000});
    check("filt_step1_lit", {16'd0, l2}, 32'h0404);

    push_expect(1'b0);
    wait_sample(n);
    check("period2", n, DIV);
    compare_sample("ay_a_hold");
    check("filt_step2_lit", {16'd0, l2}, 32'h0707);

    // ay_c alone feeds both sides
    ay_a = 8'h00;
    ay_c = 8'h40;
    push_expect(1'b0);
    wait_sample(n);
    compare_sample("ay_c");
    check("ay_c_lit", {l0, r0}, {16'h0808, 16'h0808});

    // Full default mix, and clamp on the high-SPK instance
    spk = 1'b1; ear = 1'b1; mic = 1'b1;
    ay_a = 8'hFF; ay_b = 8'hFF; ay_c = 8'hFF;
    repeat (2) @(negedge clk65);   // let ear through the synchronizer
    push_expect(1'b1);
    wait_sample(n);
    compare_sample("full");
    check("full_lit", {l0, r0}, {16'h71EE, 16'h71EE});
    check("sat_lit",  {l1, r1}, {16'h7FFF, 16'h7FFF});

    // Random mixes
    for (int i = 0; i < 4; i++) begin
      spk  = 1'($urandom_range(0, 1));
      mic  = 1'($urandom_range(0, 1));
      ear  = 1'($urandom_range(0, 1));
      ay_a = 8'($urandom_range(0, 255));
      ay_b = 8'($urandom_range(0, 255));
      ay_c = 8'($urandom_range(0, 255));
      push_expect(ear);
      wait_sample(n);
      check("rand_period", n, DIV);
      compare_sample("rand");
    end

    // ear changed one cycle before the tick is missed by that sample
    spk = 1'b0; mic = 1'b0; ear = 1'b0;
    ay_a = '0; ay_b = '0; ay_c = '0;
    push_expect(1'b0);
    repeat (128) @(negedge clk65);
    ear = 1'b1;
    wait_sample(n);
    check("ear_late_period", n, 32'd8);
    compare_sample("ear_late");

    push_expect(1'b1);
    wait_sample(n);
    compare_sample("ear_next");
    check("ear_next_lit", {l0, r0}, {16'h0E00, 16'h0E00});

    // ear changed two cycles before the tick is captured
    push_expect(1'b0);
    repeat (127) @(negedge clk65);
    ear = 1'b0;
    wait_sample(n);
    check("ear_early_period", n, 32'd9);
    compare_sample("ear_early");

    // Mid-sequence reset during S_B: partial sample discarded
    spk = 1'b1; ear = 1'b1; mic = 1'b1;
    ay_a = 8'hFF; ay_b = 8'hFF; ay_c = 8'hFF;
    push_expect(1'b1);
    wait_sample(n);
    compare_sample("pre_reset");
    spk = 1'b0; ear = 1'b0; mic = 1'b0;
    ay_a = 8'h80; ay_b = 8'h00; ay_c = 8'h00;
    k = 0;
    while (st0 != S_B && k < 200) begin
      @(negedge clk65);
      k++;
    end
    check("reach_s_b", 32'(st0), 32'(S_B));
    reset_n = 1'b0;
    #1;
    reset_checks("mid_reset");
    repeat (3) @(negedge clk65);
    reset_checks("mid_reset_hold");
    filt_l = 0;
    filt_r = 0;
    push_expect(1'b0);
    reset_n = 1'b1;
    wait_sample(n);
    check("post_reset_first_valid", n, 32'd142);
    compare_sample("post_reset");
    check("post_reset_lit", {l0, r0, l2, r2}, {16'h1010, 16'h0000, 16'h0404, 16'h0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
